// File: rtl/spi_slave_apb_pkg.sv
// Shared types for the SPI-plug / auxiliary APB arbiter.
// Holds the FSM encoding, requester indices and the timeout fill bit.
package spi_slave_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam logic REQ_SPI = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   // replicated across the data width on a completer timeout
   localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/spi_slave_apb_arbiter_rr_pick.sv
// Two-way selector: a held lock beats round-robin, a tie goes
// to whoever did not own the bus last.
module spi_slave_apb_rr_pick
   import spi_slave_apb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       lock_hold,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid  = |req;
      winner = REQ_SPI;
      if (lock_hold && req[last_grant]) begin
         winner = last_grant;
      end else if (req == 2'b11) begin
         winner = ~last_grant;
      end else if (req[REQ_AUX]) begin
         winner = REQ_AUX;
      end else begin
         winner = REQ_SPI;
      end
   end

endmodule

// File: rtl/spi_slave_apb_arbiter.sv
// Arbitrates the SPI plug and an auxiliary master onto one APB
// completer, with lock, round-robin and a completer wait timeout.
module spi_slave_apb_arbiter
   import spi_slave_apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           pclk,
   input  logic                           preset,
   input  logic [1:0]                     s_psel,
   input  logic [1:0]                     s_penable,
   input  logic [1:0]                     s_pwrite,
   input  logic [1:0]                     s_lock,
   input  logic [1:0][APB_ADDR_WIDTH-1:0] s_paddr,
   input  logic [1:0][APB_DATA_WIDTH-1:0] s_pwdata,
   output logic [1:0][APB_DATA_WIDTH-1:0] s_prdata,
   output logic [1:0]                     s_pready,
   output logic [1:0]                     s_perr,
   output logic                           psel,
   output logic                           penable,
   output logic                           pwrite,
   output logic [APB_ADDR_WIDTH-1:0]      paddr,
   output logic [APB_DATA_WIDTH-1:0]      pwdata,
   input  logic [APB_DATA_WIDTH-1:0]      prdata,
   input  logic                           pready,
   output logic                           grant_id,
   output logic                           busy
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   apb_state_e                state;
   apb_state_e                state_nx;
   logic                      last_grant;
   logic                      lock_hold;
   logic                      grant_q;
   logic                      err_q;
   logic                      write_q;
   logic [15:0]               wait_cnt;
   logic [APB_DATA_WIDTH-1:0] rsp_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic                      pick_valid;
   logic                      pick_id;
   logic                      timeout;
   logic                      deliver;
   logic                      live;

   spi_slave_apb_rr_pick u_pick (
      .req        (s_psel),
      .last_grant (last_grant),
      .lock_hold  (lock_hold),
      .valid      (pick_valid),
      .winner     (pick_id)
   );

   assign timeout = (wait_cnt == WAIT_LAST) && !pready;

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (pick_valid) state_nx = ST_SETUP;
         ST_SETUP:  state_nx = ST_ACCESS;
         ST_ACCESS: if (pready || timeout) state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state      <= ST_IDLE;
         last_grant <= REQ_AUX;
         grant_q    <= REQ_SPI;
         lock_hold  <= 1'b0;
         wait_cnt   <= '0;
         err_q      <= 1'b0;
         rsp_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick_id;
                  addr_q  <= s_paddr[pick_id];
                  wdata_q <= s_pwdata[pick_id];
                  write_q <= s_pwrite[pick_id];
               end
            end
            ST_SETUP: wait_cnt <= '0;
            ST_ACCESS: begin
               if (pready) begin
                  rsp_q <= prdata;
                  err_q <= 1'b0;
               end else if (timeout) begin
                  rsp_q <= {APB_DATA_WIDTH{TIMEOUT_FILL}};
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               last_grant <= grant_q;
               lock_hold  <= s_lock[grant_q];
            end
            default: ;
         endcase
      end
   end

   // every output reads zero while reset is held
   assign live    = !preset;
   assign deliver = live && (state == ST_RESP)
                    && s_psel[grant_q] && s_penable[grant_q];

   assign psel     = live && ((state == ST_SETUP) || (state == ST_ACCESS));
   assign penable  = live && (state == ST_ACCESS);
   assign pwrite   = live && write_q;
   assign paddr    = live ? addr_q : '0;
   assign pwdata   = live ? wdata_q : '0;
   assign busy     = live && (state != ST_IDLE);
   assign grant_id = live && grant_q;

   always_comb begin
      s_pready          = '0;
      s_perr            = '0;
      s_prdata          = '0;
      s_pready[grant_q] = deliver;
      s_perr[grant_q]   = deliver && err_q;
      s_prdata[grant_q] = deliver ? rsp_q : '0;
   end

endmodule

// File: tb/tb_spi_slave_apb_arbiter.sv
// Directed bench for the APB arbiter: requester BFMs, a delay-
// programmable completer, a vector table and corner sequences.
module tb_spi_slave_apb_arbiter;
   import spi_slave_apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   typedef struct {
      bit            wr;
      bit            lock;
      bit            drop;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      int            r;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata_in;
      int            delay;
      logic [DW-1:0] exp_data;
      bit            exp_err;
      int            exp_acc;
   } vec_t;

   logic pclk = 1'b0;
   logic preset = 1'b1;
   logic [1:0] s_psel, s_penable, s_pwrite, s_lock;
   logic [1:0] s_pready, s_perr;
   logic [1:0][AW-1:0] s_paddr;
   logic [1:0][DW-1:0] s_pwdata, s_prdata;
   logic psel, penable, pwrite, pready, grant_id, busy;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;

   always #5 pclk = ~pclk;

   spi_slave_apb_arbiter #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .s_psel    (s_psel),
      .s_penable (s_penable),
      .s_pwrite  (s_pwrite),
      .s_lock    (s_lock),
      .s_paddr   (s_paddr),
      .s_pwdata  (s_pwdata),
      .s_prdata  (s_prdata),
      .s_pready  (s_pready),
      .s_perr    (s_perr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // completer: pready after cur_delay extra access cycles
   int acc_cnt = 0;
   int cur_delay = 0;
   logic [DW-1:0] cur_prdata = '0;
   assign pready = psel && penable && (acc_cnt == cur_delay);
   assign prdata = cur_prdata;
   always @(posedge pclk)
      acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

   int n_setup = 0;
   int n_done = 0;
   int acc_run = 0;
   int acc_len = 0;
   int pr_cnt [2] = '{0, 0};
   logic [AW-1:0] su_addr = '0;
   logic [DW-1:0] su_wdata = '0;
   logic su_write = 1'b0;
   logic order [64];

   always @(posedge pclk) begin
      if (psel && !penable) begin
         su_addr  <= paddr;
         su_wdata <= pwdata;
         su_write <= pwrite;
         if (n_setup < 64) order[n_setup] <= grant_id;
         n_setup  <= n_setup + 1;
         acc_run  <= 0;
      end
      if (psel && penable) begin
         acc_run <= acc_run + 1;
         acc_len <= acc_run + 1;
         if (pready) n_done <= n_done + 1;
      end
      for (int r = 0; r < 2; r++)
         if (s_pready[r]) pr_cnt[r] <= pr_cnt[r] + 1;
   end

   cmd_t cmds [2][16];
   int n_cmd [2] = '{0, 0};
   int rd_ptr [2];
   int phase [2];
   int start_cyc [2];
   int wait_n [2];
   int res_n [2];
   logic [DW-1:0] res_data [2][16];
   bit res_err [2][16];
   int res_cyc [2][16];
   int res_lat [2][16];
   int bfm_bad;

   // requester BFMs: 1 setup, 2 enable-wait, 3 hold after pready
   initial begin : bfm
      cmd_t c;
      s_psel = '0;
      s_penable = '0;
      s_pwrite = '0;
      s_lock = '0;
      s_paddr = '0;
      s_pwdata = '0;
      bfm_bad = 0;
      for (int r = 0; r < 2; r++) begin
         rd_ptr[r] = 0;
         phase[r] = 0;
         res_n[r] = 0;
         wait_n[r] = 0;
         start_cyc[r] = 0;
      end
      forever begin
         @(negedge pclk);
         for (int r = 0; r < 2; r++) begin
            c = cmds[r][rd_ptr[r] % 16];
            if (phase[r] == 1) begin
               if (c.drop) begin
                  phase[r] = 0;
                  rd_ptr[r]++;
               end else begin
                  phase[r] = 2;
               end
            end else if (phase[r] == 2) begin
               wait_n[r]++;
               if (s_pready[r]) begin
                  res_data[r][res_n[r] % 16] = s_prdata[r];
                  res_err[r][res_n[r] % 16] = s_perr[r];
                  res_cyc[r][res_n[r] % 16] = cyc;
                  res_lat[r][res_n[r] % 16] = cyc - start_cyc[r];
                  res_n[r]++;
                  phase[r] = 3;
               end else if (wait_n[r] > 60) begin
                  bfm_bad++;
                  phase[r] = 0;
                  rd_ptr[r]++;
               end
            end else if (phase[r] == 3) begin
               phase[r] = 0;
               rd_ptr[r]++;
            end
            if (phase[r] == 0 && rd_ptr[r] < n_cmd[r]) begin
               phase[r] = 1;
               start_cyc[r] = cyc;
               wait_n[r] = 0;
            end
            c = cmds[r][rd_ptr[r] % 16];
            s_psel[r]    = (phase[r] != 0);
            s_penable[r] = (phase[r] >= 2);
            s_pwrite[r]  = (phase[r] != 0) && c.wr;
            s_lock[r]    = (phase[r] != 0) && c.lock;
            s_paddr[r]   = (phase[r] != 0) ? c.addr : '0;
            s_pwdata[r]  = (phase[r] != 0) ? c.wdata : '0;
         end
      end
   end

   int total = 0;
   int bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic push(int r, bit wr, bit lk, bit dr,
                       logic [AW-1:0] a, logic [DW-1:0] d);
      cmds[r][n_cmd[r] % 16] = '{wr: wr, lock: lk, drop: dr,
                                 addr: a, wdata: d};
      n_cmd[r]++;
   endtask

   task automatic wait_res(int r, int n);
      int k = 0;
      while (res_n[r] < n && k < 200) begin
         @(posedge pclk);
         k++;
      end
      #1;
      chk($sformatf("wait_r%0d_n%0d", r, n), 64'(res_n[r] >= n), 64'd1);
   endtask

   vec_t vt [7];

   initial begin : main
      int ns, tgt, base, nd, k;
      vt[0] = '{0, 1'b1, 32'h10, 32'hA5A5A5A5, 32'h0, 0,
                32'h0, 1'b0, 1};
      vt[1] = '{1, 1'b0, 32'h20, 32'h0, 32'h12345678, 5,
                32'h12345678, 1'b0, 6};
      vt[2] = '{0, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 2,
                32'hCAFEF00D, 1'b0, 3};
      vt[3] = '{1, 1'b1, 32'h80, 32'h11112222, 32'h0BAD0BAD, 0,
                32'h0BAD0BAD, 1'b0, 1};
      vt[4] = '{0, 1'b0, 32'h100, 32'h0, 32'h0F0F0F0F, 7,
                32'h0F0F0F0F, 1'b0, 8};
      vt[5] = '{1, 1'b0, 32'h204, 32'h0, 32'h55555555, 100,
                32'hFFFFFFFF, 1'b1, 8};
      vt[6] = '{0, 1'b0, 32'h0C, 32'h0, 32'h5A5A5A5A, 0,
                32'h5A5A5A5A, 1'b0, 1};

      preset = 1'b1;
      tick(3);
      chk("rst_psel", 64'(psel), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pready", 64'(s_pready), 64'd0);
      preset = 1'b0;
      #1;
      chk("post_busy", 64'(busy), 64'd0);
      chk("post_grant", 64'(grant_id), 64'd0);
      chk("post_paddr", 64'(paddr), 64'd0);
      chk("post_pwdata", 64'(pwdata), 64'd0);
      chk("post_ctl", 64'({psel, penable, pwrite}), 64'd0);
      chk("post_rsp", 64'({s_pready, s_perr}), 64'd0);
      chk("post_prdata", 64'(s_prdata), 64'd0);

      // tie after reset, then a second tie
      cur_delay = 0;
      cur_prdata = 32'h00000001;
      for (int t = 0; t < 2; t++) begin
         push(0, 1'b0, 1'b0, 1'b0, 32'h100 + t, 32'h0);
         push(1, 1'b0, 1'b0, 1'b0, 32'h200 + t, 32'h0);
         wait_res(0, t + 1);
         wait_res(1, t + 1);
         tick(2);
         chk($sformatf("tie%0d_first", t), 64'(order[2*t]), 64'd0);
         chk($sformatf("tie%0d_second", t), 64'(order[2*t+1]), 64'd1);
         chk($sformatf("tie%0d_gap", t),
             64'(res_cyc[1][t] - res_cyc[0][t]), 64'd4);
      end

      // req1 locks for three reads while req0 waits
      push(1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
      push(1, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0);
      push(1, 1'b0, 1'b1, 1'b0, 32'h308, 32'h0);
      tick(1);
      push(0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0);
      wait_res(1, 5);
      wait_res(0, 3);
      tick(2);
      for (int i = 0; i < 3; i++)
         chk($sformatf("lock_g%0d", i), 64'(order[4+i]), 64'd1);
      chk("lock_then_r0", 64'(order[7]), 64'd0);
      chk("lock_b2b_a", 64'(res_cyc[1][3] - res_cyc[1][2]), 64'd4);
      chk("lock_b2b_b", 64'(res_cyc[1][4] - res_cyc[1][3]), 64'd4);

      // owner drops psel before its response
      cur_delay = 0;
      base = pr_cnt[0];
      nd = n_done;
      push(0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h77);
      tick(8);
      chk("drop_downstream", 64'(n_done), 64'(nd + 1));
      chk("drop_no_pready", 64'(pr_cnt[0]), 64'(base));
      chk("drop_addr", 64'(su_addr), 64'h500);
      chk("drop_idle", 64'(busy), 64'd0);

      // reset in the middle of ACCESS; requester keeps asking
      cur_delay = 100;
      base = pr_cnt[0];
      tgt = res_n[0] + 1;
      push(0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
      k = 0;
      while (!(psel && penable) && k < 20) begin
         tick(1);
         k++;
      end
      chk("rst_mid_access", 64'(psel && penable), 64'd1);
      tick(2);
      chk("acc_prdata_zero", 64'(s_prdata), 64'd0);
      chk("acc_no_pready", 64'(s_pready), 64'd0);
      preset = 1'b1;
      #1;
      chk("rst_hold_psel", 64'(psel), 64'd0);
      tick(1);
      preset = 1'b0;
      #1;
      chk("rst_after_psel", 64'(psel), 64'd0);
      chk("rst_after_busy", 64'(busy), 64'd0);
      chk("rst_after_pready", 64'(s_pready), 64'd0);
      cur_delay = 0;
      cur_prdata = 32'h600D600D;
      tick(1);
      chk("retry_setup", 64'({psel, penable}), 64'b10);
      chk("retry_addr", 64'(paddr), 64'h600);
      wait_res(0, tgt);
      tick(1);
      chk("retry_data", 64'(res_data[0][(tgt-1) % 16]), 64'h600D600D);
      chk("retry_one_pulse", 64'(pr_cnt[0]), 64'(base + 1));
      tick(2);

      for (int i = 0; i < 7; i++) begin
         cur_delay = vt[i].delay;
         cur_prdata = vt[i].rdata_in;
         ns = n_setup;
         tgt = res_n[vt[i].r] + 1;
         push(vt[i].r, vt[i].wr, 1'b0, 1'b0, vt[i].addr, vt[i].wdata);
         wait_res(vt[i].r, tgt);
         k = (tgt - 1) % 16;
         chk($sformatf("v%0d_data", i),
             64'(res_data[vt[i].r][k]), 64'(vt[i].exp_data));
         chk($sformatf("v%0d_err", i),
             64'(res_err[vt[i].r][k]), 64'(vt[i].exp_err));
         chk($sformatf("v%0d_lat", i),
             64'(res_lat[vt[i].r][k]), 64'(2 + vt[i].exp_acc));
         chk($sformatf("v%0d_acc", i), 64'(acc_len), 64'(vt[i].exp_acc));
         chk($sformatf("v%0d_addr", i), 64'(su_addr), 64'(vt[i].addr));
         chk($sformatf("v%0d_wdata", i), 64'(su_wdata), 64'(vt[i].wdata));
         chk($sformatf("v%0d_write", i), 64'(su_write), 64'(vt[i].wr));
         chk($sformatf("v%0d_owner", i), 64'(order[ns]), 64'(vt[i].r));
         tick(2);
         chk($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
      end

      chk("bfm_wait_bound", 64'(bfm_bad), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/spi_slave_apb_arbiter.md
SPI_SLAVE_APB_ARBITER -- requirements
Module: spi_slave_apb_arbiter

Interface
REQ-001 Parameters SHALL be: APB_ADDR_WIDTH, default 32, address width; APB_DATA_WIDTH, default 32, data width; TIMEOUT_CYCLES, default 256, maximum completer wait in cycles (range 2..65535).
REQ-002 pclk  input  1  single clock; all logic on rising edge.
REQ-003 preset  input  1  reset, synchronous, active-high.
REQ-004 s_psel[1:0], s_penable[1:0], s_pwrite[1:0]  input  2 each  per-requester APB controls (index 0 = SPI plug, 1 = auxiliary master).
REQ-005 s_paddr[i]  input  APB_ADDR_WIDTH; s_pwdata[i]  input  APB_DATA_WIDTH  per-requester address and write data.
REQ-006 s_prdata[i]  output  APB_DATA_WIDTH; s_pready[1:0]  output  2; s_perr[1:0]  output  2  per-requester response, with s_perr flagging a timeout.
REQ-007 s_lock[1:0]  input  2  requester asks to keep the grant for back-to-back transfers.
REQ-008 psel, penable, pwrite  output  1; paddr  output  APB_ADDR_WIDTH; pwdata  output  APB_DATA_WIDTH  downstream APB master.
REQ-009 prdata  input  APB_DATA_WIDTH; pready  input  1  downstream completer response.
REQ-010 grant_id  output  1; busy  output  1  status: index of the current or last owner; high whenever the FSM is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; the encoding is defined in the package.
REQ-012 IDLE: if any s_psel is high, SHALL pick the winner, latch its paddr/pwrite/pwdata, set grant_id, and go to SETUP on the next edge.
REQ-013 Pick rule: exactly one s_psel high -> that requester; both high -> the requester not equal to last_grant (round-robin); last_grant resets to 1, so requester 0 wins the first tie.
REQ-014 Lock: if the previous owner's s_lock was high at its RESP and it has s_psel high in IDLE, it SHALL win regardless of round-robin; lock is ignored if that requester's s_psel is low.
REQ-015 SETUP: psel=1, penable=0, latched address/write/data driven; SHALL go to ACCESS unconditionally.
REQ-016 ACCESS: psel=1, penable=1; on pready SHALL latch prdata into the response register and go to RESP.
REQ-017 Wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready; when it reaches TIMEOUT_CYCLES-1 without pready, SHALL go to RESP with response data all-ones and the error flag set.
REQ-018 RESP: s_pready[grant_id]=1 for exactly one cycle, with s_prdata[grant_id] = latched data and s_perr[grant_id] = error flag; SHALL update last_grant and return to IDLE.
REQ-019 The response SHALL be delivered only if s_psel[grant_id] && s_penable[grant_id] in RESP; otherwise the response SHALL be dropped silently, with the downstream access still completed.
REQ-020 The losing requester's s_pready SHALL stay 0, so it stalls in its enable phase.
REQ-021 Minimum latency: capture edge to owner s_pready = 3 cycles with zero-wait completer; back-to-back transfers from one requester SHALL take 4 cycles each.
REQ-022 When not SETUP/ACCESS: psel=penable=0. The address, write and write-data outputs SHALL keep their last values.
REQ-023 s_prdata SHALL be 0 for any requester not in RESP delivery.
REQ-024 busy SHALL be high in SETUP, ACCESS and RESP.

Reset
REQ-025 preset high SHALL force IDLE, last_grant=1, grant_id=0, wait counter=0, error flag=0, response register=0, lock-hold=0.
REQ-026 During reset and on the first cycle after it, all outputs SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer on the next edge with no s_pready pulse.

Structure
REQ-028 Package spi_slave_apb_pkg SHALL hold the state enum, the requester index constants (REQ_SPI=0, REQ_AUX=1), and the timeout data constant.
REQ-029 Sub-module spi_slave_apb_rr_pick SHALL be the combinational 2-way round-robin/lock selector; the FSM, latches and counter stay in the top module.

Verification
REQ-030 Single write from req0 (addr 0x10, data 0xA5A5A5A5), pready tied 1 -> downstream SETUP then ACCESS with those values; s_pready[0] pulses 3 cycles after capture; s_perr[0]=0.
REQ-031 req0 and req1 assert s_psel on the same cycle after reset -> req0 served first, then req1; a second tie goes to req0 again.
REQ-032 req1 holds s_lock=1 for 3 reads while req0 waits -> req1 gets 3 consecutive grants; req0 is served only after lock drops.
REQ-033 Completer read with pready delayed 5 cycles, prdata 0x12345678 -> ACCESS lasts 6 cycles; s_prdata[owner]=0x12345678 in the RESP cycle.
REQ-034 pready never asserted, TIMEOUT_CYCLES=8 -> after 8 ACCESS cycles, s_pready and s_perr pulse with data 0xFFFFFFFF; FSM back in IDLE.
REQ-035 preset pulsed during ACCESS -> psel=0 and busy=0 next cycle; no s_pready; the next request starts a clean SETUP.
